// File: rtl/pipelined_cla_addsub_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   - default WIDTH / STAGES / GROUP constants
//   - cla_stage_t: per-stage pipeline payload at the default width
//     {valid, sub, sat, carry, ovf, partial sum, skewed operand bits}
//   - group_pg(): group propagate/generate over the first n bits of a group
// No ports (package).
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_GROUP  = 4;
    // Widest lookahead group group_pg() can evaluate.
    localparam int MAX_GROUP  = 32;

    // The top declares this same layout at its own WIDTH.
    typedef struct packed {
        logic                 valid;
        logic                 sub;
        logic                 sat;
        logic                 carry;
        logic                 ovf;
        logic [DEF_WIDTH-1:0] psum;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } cla_stage_t;

    // Returns {P, G} for bits [n-1:0]; bits at or above n are ignored so that
    // a trailing partial group is handled correctly.
    function automatic logic [1:0] group_pg(input logic [MAX_GROUP-1:0] p,
                                            input logic [MAX_GROUP-1:0] g,
                                            input int                   n);
        logic pp;
        logic gg;
        pp = 1'b1;
        gg = 1'b0;
        for (int i = 0; i < MAX_GROUP; i++) begin
            if (i < n) begin
                gg = g[i] | (p[i] & gg);
                pp = pp & p[i];
            end
        end
        return {pp, gg};
    endfunction

endpackage

// File: rtl/pipelined_cla_addsub_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Combinational W-bit carry-lookahead slice built from GROUP-bit lookahead
// groups (a final partial group is allowed).
// Ports:
//   a, b   in  [W-1:0]  operand bits for this slice (b already inverted for sub)
//   cin    in           carry into bit 0 of the slice
//   sum    out [W-1:0]  slice sum
//   cout   out          carry out of the slice MSB
//   cmsb   out          carry into the slice MSB (signed-overflow detection)
// -----------------------------------------------------------------------------
module cla_slice
    import cla_pkg::*;
#(
    parameter int W     = 8,
    parameter int GROUP = DEF_GROUP
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    localparam int NG = (W + GROUP - 1) / GROUP;

    logic [W-1:0]         p;
    logic [W-1:0]         g;
    logic [W:0]           c;
    logic [NG:0]          gc;
    logic [MAX_GROUP-1:0] pv;
    logic [MAX_GROUP-1:0] gv;
    logic [1:0]           pg;
    int                   n;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gc = '0;
        pv = '0;
        gv = '0;
        pg = '0;
        n  = 0;
        c  = '0;

        // Group-level carries: each group's carry-in comes from the group
        // lookahead of the previous group, not from bit ripple.
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            pv = '0;
            gv = '0;
            for (int i = 0; i < GROUP; i++) begin
                if (j * GROUP + i < W) begin
                    pv[i] = p[j * GROUP + i];
                    gv[i] = g[j * GROUP + i];
                end
            end
            n         = (W - j * GROUP < GROUP) ? (W - j * GROUP) : GROUP;
            pg        = group_pg(pv, gv, n);
            gc[j + 1] = pg[0] | (pg[1] & gc[j]);
        end

        // Bit carries inside a group; group boundaries take the lookahead carry.
        c[0] = gc[0];
        for (int i = 0; i < W; i++) begin
            if (((i + 1) % GROUP == 0) || (i == W - 1))
                c[i + 1] = gc[(i + GROUP) / GROUP];
            else
                c[i + 1] = g[i] | (p[i] & c[i]);
        end

        sum  = p ^ c[W-1:0];
        cout = c[W];
        cmsb = c[W-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is split
// into STAGES slices of WIDTH/STAGES bits; slice k is computed in pipeline
// stage k from the registered carry of stage k-1. Operands and completed sum
// slices travel with the beat, so sum/cout/ovf leave aligned after exactly
// STAGES cycles. Global-stall flow control: every stage shifts when the output
// is empty or being taken.
// Optional feature macro: PIPELINED_CLA_SAT_EN (adds the sat input; saturates
// sum to signed max/min on overflow).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   a, b [WIDTH]     operands
//   cin              carry-in, add mode only
//   sub              1: a - b (a + ~b + 1)
//   sat              (PIPELINED_CLA_SAT_EN only) saturate on signed overflow
//   out_valid/out_ready output handshake
//   sum [WIDTH]      result
//   cout             carry out of the MSB (sub: 1 = no borrow)
//   ovf              signed overflow
// -----------------------------------------------------------------------------
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int GROUP  = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PIPELINED_CLA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int BLOCK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_chk_div
        $error("pipelined_cla_addsub: WIDTH must be divisible by STAGES");
    end
    if (GROUP < 1 || GROUP > MAX_GROUP) begin : g_chk_group
        $error("pipelined_cla_addsub: GROUP out of range");
    end

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             sat;
        logic             carry;
        logic             ovf;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t [STAGES-1:0] r;
    stage_t [STAGES-1:0] nxt;
    stage_t              head;
    logic                advance;
    logic                sat_in;
    logic                unused_bits;

`ifdef PIPELINED_CLA_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // Beat as captured: B is inverted here and the carry-in forced to 1 for
    // subtraction, so the slices only ever add.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.sub   = sub;
        head.sat   = sat_in;
        head.carry = sub | cin;
        head.a     = a;
        head.b     = sub ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        logic [BLOCK-1:0] s_sum;
        logic             s_cout;
        logic             s_cmsb;

        if (k == 0) begin : g_src_in
            assign src = head;
        end else begin : g_src_reg
            assign src = r[k-1];
        end

        cla_slice #(
            .W     (BLOCK),
            .GROUP (GROUP)
        ) u_slice (
            .a    (src.a[k*BLOCK +: BLOCK]),
            .b    (src.b[k*BLOCK +: BLOCK]),
            .cin  (src.carry),
            .sum  (s_sum),
            .cout (s_cout),
            .cmsb (s_cmsb)
        );

        if (k == STAGES - 1) begin : g_last
            stage_t n;
            always_comb begin
                n                      = src;
                n.psum[k*BLOCK +: BLOCK] = s_sum;
                n.carry                = s_cout;
                // Carry into the MSB differing from carry out of it is exactly
                // "same operand signs, different result sign".
                n.ovf                  = s_cmsb ^ s_cout;
                if (n.sat && n.ovf)
                    n.psum = n.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
            end
            assign nxt[k] = n;
        end else begin : g_mid
            stage_t n;
            logic   unused_cmsb;
            always_comb begin
                n                      = src;
                n.psum[k*BLOCK +: BLOCK] = s_sum;
                n.carry                = s_cout;
                n.ovf                  = 1'b0;
            end
            assign nxt[k]      = n;
            assign unused_cmsb = s_cmsb;
        end
    end

    assign advance  = !r[STAGES-1].valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (rst)
            r <= '0;
        else if (advance)
            r <= nxt;
    end

    assign out_valid = r[STAGES-1].valid;
    assign sum       = r[STAGES-1].psum;
    assign cout      = r[STAGES-1].carry;
    assign ovf       = r[STAGES-1].ovf;

    // Low operand bits and the sub flag are not needed after their slice.
    always_comb begin
        unused_bits = 1'b0;
        for (int k = 0; k < STAGES; k++)
            unused_bits = unused_bits ^ (^r[k]);
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_addsub
// Self-checking bench for pipelined_cla_addsub (WIDTH=32, STAGES=4, GROUP=4,
// default build without PIPELINED_CLA_SAT_EN). Expected results come from a
// plain-arithmetic reference model and a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t scb[$];

    pipelined_cla_addsub #(
        .WIDTH  (32),
        .STAGES (4),
        .GROUP  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum for result/carry, signed sum for overflow.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        exp_t            e;
        logic [31:0]     ye;
        logic [63:0]     ue;
        longint          se;
        longint          cadd;
        ye   = sb ? ~y : y;
        cadd = sb ? 64'sd1 : (ci ? 64'sd1 : 64'sd0);
        ue   = {32'b0, x} + {32'b0, ye} + 64'(cadd);
        se   = longint'($signed(x)) + longint'($signed(ye)) + cadd;
        e.s  = ue[31:0];
        e.c  = ue[32];
        e.o  = (se > 64'sd2147483647) || (se < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom;
        cin = 1'b1; sub = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if ({sum, cout, ovf} !== 34'd0) begin
            failures++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b want 0/0/0", sum, cout, ovf);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_after: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
        logic [31:0] vb[4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007};
        logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        vs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] es[4] = '{32'h0000_0003, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE};
        logic        ec[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic        eo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            a = va[v]; b = vb[v]; cin = vc[v]; sub = vs[v]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d want 4", v, lat);
            end
            checks++;
            if (sum !== es[v] || cout !== ec[v] || ovf !== eo[v]) begin
                failures++;
                $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         v, sum, cout, ovf, es[v], ec[v], eo[v]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic        held;
        logic [33:0] held_val;
        int          guard;
        held = 1'b0;
        held_val = '0;
        scb.delete();
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            cin       = $urandom;
            sub       = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("FAIL random_in_ready t=%0d: got %b want %b", t, in_ready, !out_valid || out_ready);
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || {sum, cout, ovf} !== held_val) begin
                    failures++;
                    $display("FAIL random_stall_stable t=%0d: got v=%b %h want v=1 %h",
                             t, out_valid, {sum, cout, ovf}, held_val);
                end
            end
            if (in_valid && in_ready)
                scb.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                checks++;
                if (scb.size() == 0) begin
                    failures++;
                    $display("FAIL random_extra_output t=%0d: got sum=%h want no beat", t, sum);
                end else begin
                    e = scb.pop_front();
                    if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
                        failures++;
                        $display("FAIL random_result t=%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 t, sum, cout, ovf, e.s, e.c, e.o);
                    end
                end
            end
            held     = out_valid && !out_ready;
            held_val = {sum, cout, ovf};
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (scb.size() != 0 && guard < 20) begin
            @(negedge clk);
            if (out_valid) begin
                e = scb.pop_front();
                checks++;
                if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
                    failures++;
                    $display("FAIL random_drain: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, e.s, e.c, e.o);
                end
            end
            tick();
            guard++;
        end
        checks++;
        if (scb.size() != 0) begin
            failures++;
            $display("FAIL random_lost_beats: got %0d outstanding want 0", scb.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int          sent;
        int          got;
        logic [31:0] held_sum;
        sent = 0;
        got = 0;
        held_sum = '0;
        cin = 1'b0;
        sub = 1'b0;
        for (int t = 0; t < 40 && got < 8; t++) begin
            out_ready = !(t >= 6 && t <= 9);
            in_valid  = (sent < 8);
            a         = 32'(sent);
            b         = 32'(sent);
            @(negedge clk);
            if (t >= 6 && t <= 9) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_stall t=%0d: got in_ready=%b out_valid=%b want 0/1", t, in_ready, out_valid);
                end
            end
            if (t == 6)
                held_sum = sum;
            if (t >= 7 && t <= 9) begin
                checks++;
                if (sum !== held_sum) begin
                    failures++;
                    $display("FAIL b2b_stable t=%0d: got %h want %h", t, sum, held_sum);
                end
            end
            if (in_valid && in_ready)
                sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (sum !== 32'(2 * got) || cout !== 1'b0 || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h 0 0",
                             got, sum, cout, ovf, 32'(2 * got));
                end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 8 || sent !== 8) begin
            failures++;
            $display("FAIL b2b_count: got delivered=%0d accepted=%0d want 8/8", got, sent);
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_duplicate: got out_valid=%b sum=%h want 0", out_valid, sum);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stream();
        logic seen;
        int   lat;
        out_ready = 1'b1;
        cin = 1'b0;
        sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'(100 + i);
            b = 32'd1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0) begin
            failures++;
            $display("FAIL midrst_flush: got out_valid=%b sum=%h want 0/0", out_valid, sum);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ghost: got stale out_valid=%b want 0", seen);
        end
        a = 32'd10; b = 32'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 4 || sum !== 32'd30) begin
            failures++;
            $display("FAIL midrst_first_beat: got latency=%0d sum=%h want 4/%h", lat, sum, 32'd30);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
